exu_commit_q: RTL and testbench

EXU_COMMIT_Q -- requirements
Module: exu_commit_q

---
 rtl/exu_cmt_pkg.sv | 51 +++++
 rtl/exu_cmt_fifo.sv | 64 ++++++
 rtl/exu_commit_q.sv | 146 ++++++++++++++
 tb/tb_exu_commit_q.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_cmt_pkg.sv
// Shared definitions for the commit queue: state encoding, trap cause codes,
// per-entry flag layout and the packed FIFO entry format.
package exu_cmt_pkg;

  // Commit controller states
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } cmt_state_e;

  // Trap cause codes (zero-extended to XLEN when driven out)
  localparam logic [3:0] CAUSE_NONE   = 4'd0;
  localparam logic [3:0] CAUSE_ILEGL  = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK = 4'd3;
  localparam logic [3:0] CAUSE_ECALL  = 4'd11;

  // Per-entry control flags
  typedef struct packed {
    logic bjp;
    logic bjp_prdt;
    logic bjp_rslv;
    logic ebreak;
    logic ecall;
    logic ilegl;
  } cmt_flags_t;

  localparam int unsigned FLAGS_W = $bits(cmt_flags_t);

  // Entry layout, MSB to LSB: {pc[PC_SIZE], imm[XLEN], a0[XLEN], flags[FLAGS_W]}
  function automatic int unsigned cmt_entry_w(input int unsigned pc_w, input int unsigned xlen);
    return pc_w + 2 * xlen + FLAGS_W;
  endfunction

  function automatic logic cmt_has_exc(input cmt_flags_t f);
    return f.ebreak | f.ecall | f.ilegl;
  endfunction

  function automatic logic cmt_mispredict(input cmt_flags_t f);
    return f.bjp & (f.bjp_prdt ^ f.bjp_rslv);
  endfunction

  // Priority: illegal > ecall > ebreak
  function automatic logic [3:0] cmt_trap_cause(input cmt_flags_t f);
    if (f.ilegl)       return CAUSE_ILEGL;
    else if (f.ecall)  return CAUSE_ECALL;
    else if (f.ebreak) return CAUSE_EBREAK;
    else               return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/exu_cmt_fifo.sv
// In-order entry storage for the commit queue. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module exu_cmt_fifo
  import exu_cmt_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  assign do_push = push_i & ~full_o & ~clear_i;
  assign do_pop  = pop_i & ~empty_o & ~clear_i;

  // Next pointer values; clear wins over push/pop
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clear_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + (AW+1)'(1);
      if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end
  end

  // Pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Entry storage; contents are qualified by the pointers so need no reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/exu_commit_q.sv
// Commit queue: buffers ALU results in program order, retires them through a
// valid/ready handshake, redirects on branch mispredict and halts on traps.
module exu_commit_q
  import exu_cmt_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PC_SIZE = 32,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_cmt_i_valid,
  output logic               alu_cmt_i_ready,
  input  logic [PC_SIZE-1:0] alu_cmt_i_pc,
  input  logic [XLEN-1:0]    alu_cmt_i_imm,
  input  logic               alu_cmt_i_bjp,
  input  logic               alu_cmt_i_bjp_prdt,
  input  logic               alu_cmt_i_bjp_rslv,
  input  logic               alu_cmt_i_ebreak,
  input  logic               alu_cmt_i_ecall,
  input  logic               alu_cmt_i_ilegl,
  input  logic [XLEN-1:0]    alu_cmt_i_a0,
  output logic               cmt_o_valid,
  input  logic               cmt_o_ready,
  output logic [PC_SIZE-1:0] cmt_o_pc,
  output logic               flush_o_valid,
  output logic [PC_SIZE-1:0] flush_o_pc,
  output logic               commit_trap,
  output logic [XLEN-1:0]    cmt_cause,
  output logic [XLEN-1:0]    endcode,
  output logic [CNT_W-1:0]   cmt_count
);

  localparam int unsigned ENT_W = cmt_entry_w(PC_SIZE, XLEN);

  cmt_state_e         state_q;
  logic               flush_v_q;
  logic [PC_SIZE-1:0] flush_pc_q;
  logic               trap_q;
  logic [XLEN-1:0]    cause_q;
  logic [XLEN-1:0]    endcode_q;
  logic [CNT_W-1:0]   count_q;

  cmt_flags_t         enq_flags;
  cmt_flags_t         head_flags;
  logic [ENT_W-1:0]   enq_ent;
  logic [ENT_W-1:0]   head_ent;
  logic [PC_SIZE-1:0] head_pc;
  logic [XLEN-1:0]    head_imm;
  logic [XLEN-1:0]    head_a0;
  logic [3:0]         head_cause;
  logic [PC_SIZE-1:0] tgt_taken;
  logic [PC_SIZE-1:0] tgt_seq;

  logic fifo_full, fifo_empty;
  logic run, retire, trap_go, flush_go;
  logic push, pop, clear;

  assign enq_flags = '{
    bjp:      alu_cmt_i_bjp,
    bjp_prdt: alu_cmt_i_bjp_prdt,
    bjp_rslv: alu_cmt_i_bjp_rslv,
    ebreak:   alu_cmt_i_ebreak,
    ecall:    alu_cmt_i_ecall,
    ilegl:    alu_cmt_i_ilegl
  };
  assign enq_ent = {alu_cmt_i_pc, alu_cmt_i_imm, alu_cmt_i_a0, enq_flags};
  assign {head_pc, head_imm, head_a0, head_flags} = head_ent;

  exu_cmt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (clear),
    .din_i   (enq_ent),
    .dout_o  (head_ent),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Handshake and retire decode; a trap overrides a mispredict on the same head,
  // and either one discards everything younger including a same-cycle enqueue
  always_comb begin
    run             = (state_q == ST_RUN);
    alu_cmt_i_ready = ~fifo_full & run;
    cmt_o_valid     = ~fifo_empty & run;
    retire          = cmt_o_valid & cmt_o_ready;
    trap_go         = retire & cmt_has_exc(head_flags);
    flush_go        = retire & cmt_mispredict(head_flags) & ~cmt_has_exc(head_flags);
    clear           = trap_go | flush_go;
    push            = alu_cmt_i_valid & alu_cmt_i_ready & ~clear;
    pop             = retire & ~clear;
  end

  assign cmt_o_pc   = head_pc;
  assign head_cause = cmt_trap_cause(head_flags);
  // Offset is sign-extended (or truncated) to PC width before the add
  assign tgt_taken  = head_pc + PC_SIZE'(signed'(head_imm));
  assign tgt_seq    = head_pc + PC_SIZE'(4);

  // Controller state plus all registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      flush_v_q  <= 1'b0;
      flush_pc_q <= '0;
      trap_q     <= 1'b0;
      cause_q    <= '0;
      endcode_q  <= '0;
      count_q    <= '0;
    end else begin
      flush_v_q <= 1'b0;
      if (retire) count_q <= count_q + CNT_W'(1);
      case (state_q)
        ST_RUN: begin
          if (trap_go) begin
            trap_q    <= 1'b1;
            cause_q   <= XLEN'(head_cause);
            endcode_q <= (head_cause == CAUSE_EBREAK) ? head_a0 : '0;
            state_q   <= ST_HALT;
          end else if (flush_go) begin
            flush_v_q  <= 1'b1;
            flush_pc_q <= head_flags.bjp_rslv ? tgt_taken : tgt_seq;
            state_q    <= ST_FLUSH;
          end
        end
        ST_FLUSH: state_q <= ST_RUN;
        ST_HALT:  state_q <= ST_HALT;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  assign flush_o_valid = flush_v_q;
  assign flush_o_pc    = flush_pc_q;
  assign commit_trap   = trap_q;
  assign cmt_cause     = cause_q;
  assign endcode       = endcode_q;
  assign cmt_count     = count_q;

endmodule

// File: tb/tb_exu_commit_q.sv
// Directed bench for exu_commit_q: a per-cycle vector table for in-order
// retire and flush behaviour, plus hand sequences for full/wrap, traps and
// reset during flush.
module tb_exu_commit_q;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_SIZE = 32;
  localparam int unsigned CNT_W   = 32;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  localparam logic [31:0] Z = 32'h0;

  logic               clk = 1'b0;
  logic               rst;
  logic               alu_cmt_i_valid;
  logic               alu_cmt_i_ready;
  logic [PC_SIZE-1:0] alu_cmt_i_pc;
  logic [XLEN-1:0]    alu_cmt_i_imm;
  logic               alu_cmt_i_bjp, alu_cmt_i_bjp_prdt, alu_cmt_i_bjp_rslv;
  logic               alu_cmt_i_ebreak, alu_cmt_i_ecall, alu_cmt_i_ilegl;
  logic [XLEN-1:0]    alu_cmt_i_a0;
  logic               cmt_o_valid;
  logic               cmt_o_ready;
  logic [PC_SIZE-1:0] cmt_o_pc;
  logic               flush_o_valid;
  logic [PC_SIZE-1:0] flush_o_pc;
  logic               commit_trap;
  logic [XLEN-1:0]    cmt_cause;
  logic [XLEN-1:0]    endcode;
  logic [CNT_W-1:0]   cmt_count;

  int n_chk  = 0;
  int n_fail = 0;

  exu_commit_q #(
    .DEPTH   (DEPTH),
    .XLEN    (XLEN),
    .PC_SIZE (PC_SIZE),
    .CNT_W   (CNT_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .alu_cmt_i_valid    (alu_cmt_i_valid),
    .alu_cmt_i_ready    (alu_cmt_i_ready),
    .alu_cmt_i_pc       (alu_cmt_i_pc),
    .alu_cmt_i_imm      (alu_cmt_i_imm),
    .alu_cmt_i_bjp      (alu_cmt_i_bjp),
    .alu_cmt_i_bjp_prdt (alu_cmt_i_bjp_prdt),
    .alu_cmt_i_bjp_rslv (alu_cmt_i_bjp_rslv),
    .alu_cmt_i_ebreak   (alu_cmt_i_ebreak),
    .alu_cmt_i_ecall    (alu_cmt_i_ecall),
    .alu_cmt_i_ilegl    (alu_cmt_i_ilegl),
    .alu_cmt_i_a0       (alu_cmt_i_a0),
    .cmt_o_valid        (cmt_o_valid),
    .cmt_o_ready        (cmt_o_ready),
    .cmt_o_pc           (cmt_o_pc),
    .flush_o_valid      (flush_o_valid),
    .flush_o_pc         (flush_o_pc),
    .commit_trap        (commit_trap),
    .cmt_cause          (cmt_cause),
    .endcode            (endcode),
    .cmt_count          (cmt_count)
  );

  always #5 clk = ~clk;

  // Flags field order: {bjp, prdt, rslv, ebreak, ecall, ilegl}
  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [5:0]  fl;
    logic [31:0] a0;
    logic        crdy;
    logic        e_rdy;
    logic        e_cv;
    logic [31:0] e_cpc;
    logic        e_fv;
    logic [31:0] e_fpc;
    logic [31:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [5:0] fl, input logic [31:0] a0, input logic crdy,
                              input logic e_rdy, input logic e_cv, input logic [31:0] e_cpc,
                              input logic e_fv, input logic [31:0] e_fpc, input logic [31:0] e_cnt);
    vec_t r;
    r.v = v; r.pc = pc; r.imm = imm; r.fl = fl; r.a0 = a0; r.crdy = crdy;
    r.e_rdy = e_rdy; r.e_cv = e_cv; r.e_cpc = e_cpc;
    r.e_fv = e_fv; r.e_fpc = e_fpc; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                     input logic [5:0] fl, input logic [31:0] a0, input logic crdy);
    alu_cmt_i_valid = v;
    alu_cmt_i_pc    = pc;
    alu_cmt_i_imm   = imm;
    {alu_cmt_i_bjp, alu_cmt_i_bjp_prdt, alu_cmt_i_bjp_rslv,
     alu_cmt_i_ebreak, alu_cmt_i_ecall, alu_cmt_i_ilegl} = fl;
    alu_cmt_i_a0    = a0;
    cmt_o_ready     = crdy;
  endtask

  // One clock: drive at negedge, check handshake before the edge, status after it
  task automatic step(input vec_t t, input string tag);
    @(negedge clk);
    drv(t.v, t.pc, t.imm, t.fl, t.a0, t.crdy);
    #1;
    chk({tag, ".ready"},  {31'b0, alu_cmt_i_ready}, {31'b0, t.e_rdy});
    chk({tag, ".cvalid"}, {31'b0, cmt_o_valid},     {31'b0, t.e_cv});
    if (t.e_cv) chk({tag, ".cpc"}, cmt_o_pc, t.e_cpc);
    @(posedge clk);
    #1;
    chk({tag, ".fvalid"}, {31'b0, flush_o_valid}, {31'b0, t.e_fv});
    if (t.e_fv) chk({tag, ".fpc"}, flush_o_pc, t.e_fpc);
    chk({tag, ".count"}, cmt_count, t.e_cnt);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".fvalid"}, {31'b0, flush_o_valid}, Z);
    chk({tag, ".fpc"},    flush_o_pc,  Z);
    chk({tag, ".trap"},   {31'b0, commit_trap}, Z);
    chk({tag, ".cause"},  cmt_cause,   Z);
    chk({tag, ".endcode"}, endcode,    Z);
    chk({tag, ".count"},  cmt_count,   Z);
    chk({tag, ".cvalid"}, {31'b0, cmt_o_valid}, Z);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    drv(F, Z, Z, 6'b0, Z, F);
    rst = 1'b0;
    #1;
    chk_reset_vals(tag);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Retire one trapping head and check the latched trap status, then refusal in HALT
  task automatic trap_case(input string tag, input logic [5:0] fl, input logic [31:0] a0,
                           input logic [31:0] e_cause, input logic [31:0] e_end);
    do_reset({tag, ".rst"});
    step(mk(T, 32'h80000100, 32'h40, fl, a0, F, T, F, Z, F, Z, 32'd0), {tag, ".push"});
    step(mk(T, 32'h80000104, Z, 6'b0, Z, F, T, T, 32'h80000100, F, Z, 32'd0), {tag, ".young"});
    step(mk(F, Z, Z, 6'b0, Z, T, T, T, 32'h80000100, F, Z, 32'd1), {tag, ".retire"});
    chk({tag, ".trap"},    {31'b0, commit_trap}, 32'd1);
    chk({tag, ".cause"},   cmt_cause, e_cause);
    chk({tag, ".endcode"}, endcode,   e_end);
    step(mk(T, 32'h80000200, Z, 6'b0, Z, T, F, F, Z, F, Z, 32'd1), {tag, ".halt0"});
    step(mk(T, 32'h80000204, Z, 6'b0, Z, T, F, F, Z, F, Z, 32'd1), {tag, ".halt1"});
    chk({tag, ".trap_hold"},  {31'b0, commit_trap}, 32'd1);
    chk({tag, ".cause_hold"}, cmt_cause, e_cause);
    chk({tag, ".end_hold"},   endcode,   e_end);
  endtask

  vec_t tbl [18];

  initial begin
    // In-order retire with back-to-back enqueue, then mispredict flushes
    tbl[0]  = mk(T, 32'h80000000, Z,      6'b000000, Z, T,  T, F, Z,            F, Z,            32'd0);
    tbl[1]  = mk(T, 32'h80000004, Z,      6'b000000, Z, T,  T, T, 32'h80000000, F, Z,            32'd1);
    tbl[2]  = mk(T, 32'h80000008, Z,      6'b000000, Z, T,  T, T, 32'h80000004, F, Z,            32'd2);
    tbl[3]  = mk(T, 32'h8000000C, Z,      6'b000000, Z, T,  T, T, 32'h80000008, F, Z,            32'd3);
    tbl[4]  = mk(F, Z,            Z,      6'b000000, Z, T,  T, T, 32'h8000000C, F, Z,            32'd4);
    tbl[5]  = mk(F, Z,            Z,      6'b000000, Z, T,  T, F, Z,            F, Z,            32'd4);
    tbl[6]  = mk(T, 32'h80000010, 32'h20, 6'b101000, Z, F,  T, F, Z,            F, Z,            32'd4);
    tbl[7]  = mk(T, 32'h80000014, Z,      6'b000000, Z, F,  T, T, 32'h80000010, F, Z,            32'd4);
    tbl[8]  = mk(T, 32'h80000018, Z,      6'b000000, Z, F,  T, T, 32'h80000010, F, Z,            32'd4);
    tbl[9]  = mk(T, 32'h8000001C, Z,      6'b000000, Z, T,  T, T, 32'h80000010, T, 32'h80000030, 32'd5);
    tbl[10] = mk(F, Z,            Z,      6'b000000, Z, T,  F, F, Z,            F, Z,            32'd5);
    tbl[11] = mk(F, Z,            Z,      6'b000000, Z, T,  T, F, Z,            F, Z,            32'd5);
    tbl[12] = mk(T, 32'h80000040, 32'h100,6'b110000, Z, T,  T, F, Z,            F, Z,            32'd5);
    tbl[13] = mk(F, Z,            Z,      6'b000000, Z, T,  T, T, 32'h80000040, T, 32'h80000044, 32'd6);
    tbl[14] = mk(F, Z,            Z,      6'b000000, Z, T,  F, F, Z,            F, Z,            32'd6);
    tbl[15] = mk(T, 32'h80000050, 32'h8,  6'b111000, Z, T,  T, F, Z,            F, Z,            32'd6);
    tbl[16] = mk(F, Z,            Z,      6'b000000, Z, T,  T, T, 32'h80000050, F, Z,            32'd7);
    tbl[17] = mk(F, Z,            Z,      6'b000000, Z, T,  T, F, Z,            F, Z,            32'd7);

    rst = 1'b1;
    drv(F, Z, Z, 6'b0, Z, F);
    do_reset("init");

    for (int i = 0; i < 18; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Fill to full with no retire, refuse the fifth, drain; twice to wrap pointers
    for (int r = 0; r < 2; r++) begin
      logic [31:0] base;
      logic [31:0] cnt0;
      base = (r == 0) ? 32'h90000000 : 32'hA0000000;
      cnt0 = 32'd7 + 32'(r) * 32'd4;
      for (int i = 0; i < 4; i++)
        step(mk(T, base + 32'(i) * 32'd4, Z, 6'b0, Z, F, T, (i != 0), base, F, Z, cnt0),
             $sformatf("fill%0d_%0d", r, i));
      step(mk(T, base + 32'hF0, Z, 6'b0, Z, F, F, T, base, F, Z, cnt0), $sformatf("full%0d", r));
      for (int i = 0; i < 4; i++)
        step(mk(F, Z, Z, 6'b0, Z, T, (i != 0), T, base + 32'(i) * 32'd4, F, Z, cnt0 + 32'(i) + 32'd1),
             $sformatf("drain%0d_%0d", r, i));
      step(mk(F, Z, Z, 6'b0, Z, T, T, F, Z, F, Z, cnt0 + 32'd4), $sformatf("empty%0d", r));
    end

    // Traps: ilegl+ecall+mispredict, plain ebreak (a0=0), ebreak with data, ecall over ebreak
    trap_case("trap_all", 6'b101011, 32'h00000055, 32'd2,  Z);
    trap_case("ebreak0",  6'b000100, Z,            32'd3,  Z);
    trap_case("ebreakA",  6'b000100, 32'h0000CAFE, 32'd3,  32'h0000CAFE);
    trap_case("ecall",    6'b000110, 32'h0000BEEF, 32'd11, Z);

    // Reset asserted while in FLUSH, then push on the first edge after release
    do_reset("rf.rst0");
    step(mk(T, 32'h80000200, 32'h10, 6'b101000, Z, T, T, F, Z, F, Z, 32'd0), "rf.push");
    step(mk(F, Z, Z, 6'b0, Z, T, T, T, 32'h80000200, T, 32'h80000210, 32'd1), "rf.flush");
    rst = 1'b0;
    #1;
    chk_reset_vals("rf.async");
    @(negedge clk);
    rst = 1'b1;
    drv(T, 32'h80000300, Z, 6'b0, Z, T);
    #1;
    chk("rf.ready_rel",  {31'b0, alu_cmt_i_ready}, 32'd1);
    chk("rf.cvalid_rel", {31'b0, cmt_o_valid},     32'd0);
    @(posedge clk);
    #1;
    step(mk(F, Z, Z, 6'b0, Z, T, T, T, 32'h80000300, F, Z, 32'd1), "rf.retire");
    step(mk(F, Z, Z, 6'b0, Z, T, T, F, Z, F, Z, 32'd1), "rf.idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
